// File: rtl/bus_slave_ram_rd_if.sv
// AXI3 read-address and read-data channel bundle between a bus master and
// the RAM read responder.
interface bus_slave_ram_rd_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/bus_slave_ram_rd.sv
// AXI3 read responder in front of a 1-cycle-latency synchronous RAM: one burst at a
// time, FIXED/INCR/WRAP address generation, 2-entry output buffer for full rate.
//
//   state   | meaning
//   S_IDLE  | arready high, waiting for an AR handshake
//   S_BURST | issuing RAM reads and streaming R beats until the rlast handshake
module bus_slave_ram_rd #(
  parameter int RAM_AW = 12,
  parameter int ID_W   = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  bus_slave_ram_rd_if.slave   bus,
  output logic                ram_en,
  output logic [RAM_AW-1:0]   ram_addr,
  input  logic [31:0]         ram_rdata
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;
  localparam logic [RAM_AW-1:0] ADDR_ONE = {{(RAM_AW-1){1'b0}}, 1'b1};

  logic [0:0]        state;
  logic              arready_q;
  logic [ID_W-1:0]   id_q;
  logic [RAM_AW-1:0] addr_q;
  logic [3:0]        len_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic [4:0]        issued_q;
  logic              inflight_q;
  logic              inflight_last_q;

  logic [31:0]       buf_data [2];
  logic              buf_last [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count_q;

  logic              ar_hs;
  logic              ar_err;
  logic              rvalid;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occ;
  logic [4:0]        n_beats;
  logic [RAM_AW-1:0] addr_inc;
  logic [RAM_AW-1:0] wrap_mask;
  logic [RAM_AW-1:0] next_addr;
  logic              unused_ok;

  assign unused_ok = ^{bus.arlock, bus.arcache, bus.arprot,
                       bus.araddr[31:RAM_AW+2], bus.araddr[1:0]};

  assign ar_hs  = bus.arvalid & arready_q;
  assign ar_err = (bus.arsize != 3'b010) || (bus.arburst == 2'b11) ||
                  ((bus.arburst == 2'b10) && !((bus.arlen == 4'd1) || (bus.arlen == 4'd3) ||
                                               (bus.arlen == 4'd7) || (bus.arlen == 4'd15)));

  assign rvalid  = (count_q != 2'd0);
  assign pop     = rvalid & bus.rready;
  assign push    = inflight_q;
  assign n_beats = {1'b0, len_q} + 5'd1;
  // Slots already committed (buffered plus the read landing this cycle), less the beat leaving now.
  assign occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = (state == S_BURST) && (issued_q != n_beats) && (occ < 3'd2);

  assign ram_en   = issue & ~err_q;
  assign ram_addr = addr_q;

  assign addr_inc  = addr_q + ADDR_ONE;
  assign wrap_mask = {{(RAM_AW-4){1'b0}}, len_q};

  always_comb begin
    next_addr = addr_q;
    case (burst_q)
      2'b01:   next_addr = addr_inc;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default: next_addr = addr_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= S_IDLE;
      arready_q       <= 1'b0;
      id_q            <= '0;
      addr_q          <= '0;
      len_q           <= '0;
      burst_q         <= '0;
      err_q           <= 1'b0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= (issued_q == {1'b0, len_q});
      case (state)
        S_IDLE: begin
          if (ar_hs) begin
            id_q      <= bus.arid;
            addr_q    <= bus.araddr[RAM_AW+1:2];
            len_q     <= bus.arlen;
            burst_q   <= bus.arburst;
            err_q     <= ar_err;
            issued_q  <= '0;
            arready_q <= 1'b0;
            state     <= S_BURST;
          end else begin
            arready_q <= 1'b1;
          end
        end
        default: begin
          if (issue) begin
            issued_q <= issued_q + 5'd1;
            addr_q   <= next_addr;
          end
          if (pop && buf_last[rd_ptr]) begin
            state     <= S_IDLE;
            arready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= '0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= err_q ? 32'd0 : ram_rdata;
        buf_last[wr_ptr] <= inflight_last_q;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // err_q only changes in S_IDLE, after the last beat has left, so it is valid for every head beat.
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid;
  assign bus.rid     = id_q;
  assign bus.rdata   = buf_data[rd_ptr];
  assign bus.rlast   = rvalid & buf_last[rd_ptr];
  assign bus.rresp   = (rvalid && err_q) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_bus_slave_ram_rd.sv
// Scoreboard bench for bus_slave_ram_rd: a bench-side burst model queues expected
// RAM addresses and R beats, and a negedge monitor compares them as the DUT produces them.
module tb_bus_slave_ram_rd;

  logic        aclk;
  logic        aresetn;
  logic        ram_en;
  logic [11:0] ram_addr;
  logic [31:0] ram_rdata;
  logic [31:0] mem [0:4095];

  int          n_checks;
  int          n_errors;
  int          cyc;
  int          n_en;
  int          n_pop;
  int          max_outst;
  logic        rready_mode;
  logic        stalled_prev;
  logic [32:0] held;

  logic [63:0] sb [$];
  logic [11:0] exp_addr [$];

  bus_slave_ram_rd_if #(.ID_W(4)) bus ();

  bus_slave_ram_rd #(.RAM_AW(12), .ID_W(4)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .bus       (bus),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc++;

  always @(posedge aclk) if (ram_en) ram_rdata <= mem[ram_addr];

  always @(posedge aclk) begin
    #1;
    bus.rready = rready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge aclk) begin
    if (!aresetn) begin
      stalled_prev = 1'b0;
    end else begin
      if (ram_en) begin
        n_en++;
        if (exp_addr.size() == 0) check("unexpected_ram_en", 64'(ram_addr), 64'hffff);
        else check("ram_addr", 64'(ram_addr), 64'(exp_addr.pop_front()));
      end
      if (bus.rvalid && bus.rready) begin
        n_pop++;
        if (sb.size() == 0) check("unexpected_beat", 64'(bus.rdata), 64'hffff_ffff_ffff);
        else check("beat", 64'({bus.rid, bus.rresp, bus.rlast, bus.rdata}), sb.pop_front());
      end
      if (n_en - n_pop > max_outst) max_outst = n_en - n_pop;
      if (stalled_prev && bus.rvalid) check("stall_stable", 64'({bus.rlast, bus.rdata}), 64'(held));
      stalled_prev = bus.rvalid && !bus.rready;
      held = {bus.rlast, bus.rdata};
    end
  end

  // Bench model of one burst, queued after the AR handshake.
  task automatic model_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    int  n, w, lower, a;
    bit  err;
    err = (size != 3'b010) || (burst == 2'b11) ||
          (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    n = int'(len) + 1;
    w = int'(addr[13:2]);
    lower = (w / n) * n;
    for (int i = 0; i < n; i++) begin
      case (burst)
        2'b01:   a = (w + i) % 4096;
        2'b10:   a = lower + ((w - lower + i) % n);
        default: a = w;
      endcase
      if (!err) exp_addr.push_back(12'(a));
      sb.push_back(64'({id, (err ? 2'b10 : 2'b00), (i == n - 1), (err ? 32'd0 : mem[a])}));
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int ar_cyc);
    bit ok;
    ok = 1'b0;
    @(posedge aclk); #1;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (bus.arready) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
    ar_cyc = cyc;
    bus.arvalid = 1'b0;
    if (ok) model_burst(id, addr, len, size, burst);
    else check("ar_accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge aclk);
      if (sb.size() == 0 && bus.arready) begin ok = 1'b1; break; end
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    int ar_cyc, first_rv, run, base, en0;
    bit seen;
    n_checks = 0; n_errors = 0; cyc = 0; n_en = 0; n_pop = 0; max_outst = 0;
    stalled_prev = 1'b0; held = '0; rready_mode = 1'b0; ram_rdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'b010; bus.arburst = 2'b01;
    bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    aresetn = 1'b0;
    #2;
    check("reset_outputs", 64'({bus.arready, bus.rvalid, bus.rlast, bus.rid, bus.rdata, bus.rresp,
                                ram_en, ram_addr}), 64'd0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("arready_before_edge", 64'(bus.arready), 64'd0);
    @(negedge aclk);
    check("arready_after_release", 64'(bus.arready), 64'd1);

    // INCR, WRAP, FIXED with rready held high
    send_ar(4'd1, 32'h10, 4'd3, 3'b010, 2'b01, ar_cyc);
    wait_done("drain_incr");
    send_ar(4'd2, 32'h38, 4'd3, 3'b010, 2'b10, ar_cyc);
    wait_done("drain_wrap");
    send_ar(4'd3, 32'h20, 4'd2, 3'b010, 2'b00, ar_cyc);
    wait_done("drain_fixed");

    // 16-beat INCR at full rate: first rvalid at AR+2, then 16 back-to-back beats
    send_ar(4'd4, 32'h400, 4'd15, 3'b010, 2'b01, ar_cyc);
    first_rv = -1; seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge aclk);
      if (bus.rvalid) begin first_rv = cyc; seen = 1'b1; break; end
    end
    check("first_rvalid_latency", 64'(first_rv - ar_cyc), 64'd2);
    run = 0;
    while (seen && bus.rvalid && bus.rready && run < 40) begin
      run++;
      @(negedge aclk);
    end
    check("consecutive_beats", 64'(run), 64'd16);
    wait_done("drain_incr16");

    // 16-beat INCR near the top of the RAM under random backpressure (wraps mod 4096)
    rready_mode = 1'b1;
    send_ar(4'd5, 32'h3FE8, 4'd15, 3'b010, 2'b01, ar_cyc);
    wait_done("drain_incr16_bp");
    send_ar(4'd6, 32'h74, 4'd7, 3'b010, 2'b10, ar_cyc);
    wait_done("drain_wrap8_bp");
    rready_mode = 1'b0;
    check("max_outstanding_le2", 64'(max_outst <= 2), 64'd1);

    // error bursts: reserved burst, bad WRAP length, bad size
    en0 = n_en;
    send_ar(4'd7, 32'h40, 4'd1, 3'b010, 2'b11, ar_cyc);
    wait_done("drain_err_burst");
    send_ar(4'd8, 32'h40, 4'd2, 3'b010, 2'b10, ar_cyc);
    wait_done("drain_err_wrap");
    send_ar(4'd9, 32'h40, 4'd0, 3'b001, 2'b01, ar_cyc);
    wait_done("drain_err_size");
    check("err_no_ram_en", 64'(n_en - en0), 64'd0);
    send_ar(4'd10, 32'h44, 4'd1, 3'b010, 2'b01, ar_cyc);
    wait_done("drain_after_err");

    // reset in the middle of an 8-beat burst
    send_ar(4'd11, 32'h100, 4'd7, 3'b010, 2'b01, ar_cyc);
    base = n_pop;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (n_pop - base >= 2) break;
    end
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    check("midburst_reset_outputs", 64'({bus.arready, bus.rvalid, bus.rlast, bus.rid, bus.rdata,
                                         bus.rresp, ram_en, ram_addr}), 64'd0);
    sb.delete();
    exp_addr.delete();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("arready_before_edge2", 64'(bus.arready), 64'd0);
    @(negedge aclk);
    check("arready_after_release2", 64'(bus.arready), 64'd1);
    send_ar(4'd12, 32'h0, 4'd3, 3'b010, 2'b01, ar_cyc);
    wait_done("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
